mat2x2_mult_core: RTL and testbench
===================================

# mat2x2_mult_core

Tiny Tapeout user core computing C = A×B for 2×2 matrices of 4-bit unsigned elements. It sits directly downstream of the board-level wrapper, which supplies the halved clock and resolves the bidirectional pins. Operands stream in one byte per cycle on `ui_in` under a valid strobe. Four 9-bit results stream out on `uo_out` plus one `uio` bit under a valid/ready handshake.

## Interface

- no parameters (element width 4, result width 9, fixed)
- `clk` input 1: core clock
- `rst_n` input 1: reset, synchronous, active-low
- `ena` input 1: clock enable; low = all state held
- `ui_in` input 8: operand byte, {hi nibble, lo nibble}
- `uo_out` output 8: result bits [7:0]
- `uio_in` input 8: [0] in_valid, [1] out_ready, others ignored
- `uio_out` output 8: [7] result bit 8, [6] out_valid, [5] busy, [4:0] = 0
- `uio_oe` output 8: constant 8'b1110_0000

## Operation

- Operand byte order, k = 0..3:
  - k=0 {a01,a00}
  - k=1 {a11,a10}
  - k=2 {b01,b00}
  - k=3 {b11,b10}
  - Low nibble is the lower column index.
- Result: c_ij = a_i0·b_0j + a_i1·b_1j, unsigned, 9 bits.
  - Max 2·15·15 = 450; no overflow possible.
- FSM states LOAD, CALC, SEND.
  - **LOAD:** each edge with ena=1 and in_valid=1 stores `ui_in` into slot `ld_cnt`, then increments it. Storing slot 3 goes to CALC with `calc_cnt` = 0. in_valid=0 holds; gaps are allowed.
  - **CALC:** one result per edge, in order c00, c01, c10, c11, into result registers r0..r3. After r3 is written: go to SEND, `out_idx` = 0.
  - **SEND:** `{uio_out[7], uo_out}` = r[out_idx]; out_valid=1. A transfer happens on an edge with out_valid=1 and out_ready=1; `out_idx` increments. Transfer of index 3 returns to LOAD with `ld_cnt` = 0 and out_valid=0.
- in_valid is ignored in CALC and SEND; those bytes are dropped, not queued.
- busy = (state ≠ LOAD).
- Operand registers are overwritten only by new loads. Result registers are overwritten only in CALC.
- `uo_out` and `uio_out[7]` are 0 whenever state ≠ SEND.

## Timing

- Reset (rst_n=0 at an edge), from any state including mid-load or mid-send:
  - state=LOAD, all counters 0, operands and results 0.
  - Partial loads and unsent results are discarded; nothing is resumed.
  - Outputs: `uo_out`=0, `uio_out`=0, `uio_oe`=8'hE0.
- rst_n has priority over ena.
- ena=0: no state, counter or register changes. Outputs keep their current values. A handshake during ena=0 does not count.
- Latency, with byte 3 accepted on edge N:
  - busy=1 after edge N.
  - r0..r3 written on edges N+1..N+4.
  - out_valid=1 after edge N+4.
- With out_ready held at 1: transfers on edges N+5..N+8; busy=0 and out_valid=0 after N+8; the next byte can be accepted on edge N+9.
- out_ready=0 in SEND holds `out_idx` and all output values indefinitely.
- All outputs are register-driven, or muxed from registers by registered state. There is no combinational path from any input to any output.

## Test plan

- **Basic:** A=[[1,2],[3,4]], B=[[5,6],[7,8]]; bytes 0x21, 0x43, 0x65, 0x87 with in_valid=1 on consecutive cycles; out_ready=1.
  - Required outputs in order: 19, 22, 43, 50 (bit 8 = 0).
  - out_valid first high 4 cycles after the last byte.
- **Max value:** all elements 15 (bytes 0xFF ×4).
  - All four results are 450: `uo_out`=0xC2, `uio_out[7]`=1.
- **Backpressure and gaps:** in_valid deasserted 3 cycles between bytes; out_ready toggles 1,0,0,1,...
  - Results are unchanged and each is held while out_ready=0.
  - Exactly 4 transfers occur, then busy=0.
- **Ignored input:** pulse in_valid with 0xAA during CALC and SEND, then load the identity A (0x01, 0x10) and B=[[5,6],[7,8]].
  - Results: 5, 6, 7, 8. The 0xAA bytes have no effect.
- **Reset mid-operation:** assert rst_n=0 after 2 bytes.
  - All outputs 0, busy=0.
  - A subsequent full 4-byte load yields the correct products.
  - Repeat with reset asserted during SEND after 1 transfer.
- **Enable:** ena=0 for 5 cycles in each of LOAD, CALC and SEND while in_valid and out_ready toggle.
  - No state advance; the final results equal those of the ena=1 run.

Source files
------------

// File: rtl/mat2x2_mult_core.sv
// mat2x2_mult_core: computes C = A x B for 2x2 matrices of 4-bit unsigned elements.
// Operands arrive one byte per cycle on ui_in (gated by uio_in[0]); the four 9-bit
// results leave on {uio_out[7], uo_out} under an out_valid/out_ready handshake.
//
// Ports:
//   clk      core clock
//   rst_n    synchronous active-low reset (priority over ena)
//   ena      clock enable; low holds every register
//   ui_in    operand byte {hi nibble, lo nibble}
//   uo_out   result bits [7:0]
//   uio_in   [0] in_valid, [1] out_ready, [7:2] unused
//   uio_out  [7] result bit 8, [6] out_valid, [5] busy, [4:0] zero
//   uio_oe   constant 8'hE0
module mat2x2_mult_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned EW    = 4;
   localparam int unsigned PW    = 2 * EW;
   localparam int unsigned RW    = PW + 1;
   localparam int unsigned NSLOT = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ld_cnt_q, ld_cnt_d;
   logic [1:0]    calc_cnt_q, calc_cnt_d;
   logic [1:0]    out_idx_q, out_idx_d;
   logic [7:0]    op_q  [NSLOT];
   logic [7:0]    op_d  [NSLOT];
   logic [RW-1:0] res_q [NSLOT];
   logic [RW-1:0] res_d [NSLOT];
   logic [RW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;

   logic in_valid;
   logic out_ready;
   logic unused_uio;

   assign in_valid   = uio_in[0];
   assign out_ready  = uio_in[1];
   assign unused_uio = &{1'b0, uio_in[7:2]};

   // Element selection for c_ij with {i,j} = calc_cnt
   logic          ci, cj;
   logic [EW-1:0] a_x0, a_x1, b_0x, b_1x;
   logic [PW-1:0] prod0, prod1;
   logic [RW-1:0] c_val;

   always_comb begin
      ci    = calc_cnt_q[1];
      cj    = calc_cnt_q[0];
      a_x0  = op_q[{1'b0, ci}][EW-1:0];
      a_x1  = op_q[{1'b0, ci}][PW-1:EW];
      b_0x  = cj ? op_q[2][PW-1:EW] : op_q[2][EW-1:0];
      b_1x  = cj ? op_q[3][PW-1:EW] : op_q[3][EW-1:0];
      prod0 = {4'b0, a_x0} * {4'b0, b_0x};
      prod1 = {4'b0, a_x1} * {4'b0, b_1x};
      c_val = {1'b0, prod0} + {1'b0, prod1};
   end

   // Next-state, datapath updates and next output values
   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      calc_cnt_d = calc_cnt_q;
      out_idx_d  = out_idx_q;
      op_d       = op_q;
      res_d      = res_q;

      case (state_q)
         LOAD: begin
            if (in_valid) begin
               op_d[ld_cnt_q] = ui_in;
               ld_cnt_d       = ld_cnt_q + 2'd1;
               if (ld_cnt_q == 2'd3) begin
                  state_d    = CALC;
                  calc_cnt_d = 2'd0;
               end
            end
         end
         CALC: begin
            res_d[calc_cnt_q] = c_val;
            calc_cnt_d        = calc_cnt_q + 2'd1;
            if (calc_cnt_q == 2'd3) begin
               state_d   = SEND;
               out_idx_d = 2'd0;
            end
         end
         SEND: begin
            if (valid_q && out_ready) begin
               out_idx_d = out_idx_q + 2'd1;
               if (out_idx_q == 2'd3) begin
                  state_d  = LOAD;
                  ld_cnt_d = 2'd0;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase

      // Outputs are registered copies of what the next state presents
      valid_d = (state_d == SEND);
      busy_d  = (state_d != LOAD);
      data_d  = valid_d ? res_d[out_idx_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         ld_cnt_q   <= 2'd0;
         calc_cnt_q <= 2'd0;
         out_idx_q  <= 2'd0;
         for (int i = 0; i < NSLOT; i++) begin
            op_q[i]  <= '0;
            res_q[i] <= '0;
         end
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else if (ena) begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         calc_cnt_q <= calc_cnt_d;
         out_idx_q  <= out_idx_d;
         op_q       <= op_d;
         res_q      <= res_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   assign uo_out  = data_q[7:0];
   assign uio_out = {data_q[8], valid_q, busy_q, 5'b0};
   assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_mat2x2_mult_core.sv
// Directed testbench for mat2x2_mult_core with hand-computed products.
module tb_mat2x2_mult_core;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       in_valid;
   logic       out_ready;

   int checks;
   int errors;

   assign uio_in = {6'b0, out_ready, in_valid};

   mat2x2_mult_core dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load4(input logic [7:0] b0, b1, b2, b3);
      logic [7:0] bytes [4];
      bytes = '{b0, b1, b2, b3};
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         ui_in    = bytes[k];
         tick();
      end
      in_valid = 1'b0;
      ui_in    = 8'h00;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !uio_out[6]; i++) tick();
      checks++;
      if (uio_out[6] !== 1'b1) begin
         errors++;
         $display("FAIL wait_valid: out_valid=%b required 1 within 20 cycles", uio_out[6]);
      end
   endtask

   // Accept all four results with out_ready=1 and compare each one
   task automatic drain_results(input string name, input logic [8:0] e0, e1, e2, e3);
      logic [8:0] exp_v [4];
      exp_v = '{e0, e1, e2, e3};
      out_ready = 1'b1;
      wait_valid();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({uio_out[7], uo_out} !== exp_v[k] || uio_out[6] !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d]: data=%0d valid=%b required data=%0d valid=1",
                     name, k, {uio_out[7], uo_out}, uio_out[6], exp_v[k]);
         end
         tick();
      end
      checks++;
      if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
         errors++;
         $display("FAIL %s_done: uio_out=%h uo_out=%h required 00/00", name, uio_out, uo_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
         errors++;
         $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h required 00/00/e0",
                  uo_out, uio_out, uio_oe);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      load4(8'h21, 8'h43, 8'h65, 8'h87);
      checks++;
      if (uio_out[5] !== 1'b1 || uio_out[6] !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy: busy=%b valid=%b required busy=1 valid=0",
                  uio_out[5], uio_out[6]);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (uio_out[6] !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency N+%0d: valid=%b required 0", i, uio_out[6]);
         end
      end
      tick();
      checks++;
      if (uio_out[6] !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency N+4: valid=%b required 1", uio_out[6]);
      end
      drain_results("basic", 9'd19, 9'd22, 9'd43, 9'd50);
   endtask

   task automatic test_max();
      load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      wait_valid();
      checks++;
      if (uo_out !== 8'hC2 || uio_out[7] !== 1'b1) begin
         errors++;
         $display("FAIL max_bits: uo_out=%h bit8=%b required c2/1", uo_out, uio_out[7]);
      end
      drain_results("max", 9'd450, 9'd450, 9'd450, 9'd450);
   endtask

   task automatic test_backpressure();
      logic [8:0] exp_v [4];
      logic [7:0] bytes [4];
      int idx;
      int xfers;
      exp_v = '{9'd36, 9'd41, 9'd64, 9'd73};
      bytes = '{8'h32, 8'h54, 8'h76, 8'h98};
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         ui_in    = bytes[k];
         tick();
         in_valid = 1'b0;
         for (int g = 0; g < 3; g++) tick();
      end
      out_ready = 1'b0;
      wait_valid();
      idx   = 0;
      xfers = 0;
      for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
         out_ready = (cyc % 3 == 0);
         checks++;
         if ({uio_out[7], uo_out} !== exp_v[idx] || uio_out[6] !== 1'b1) begin
            errors++;
            $display("FAIL bp_data[%0d] cyc %0d: data=%0d valid=%b required data=%0d valid=1",
                     idx, cyc, {uio_out[7], uo_out}, uio_out[6], exp_v[idx]);
         end
         tick();
         if (out_ready) begin
            idx++;
            xfers++;
         end
      end
      out_ready = 1'b0;
      tick();
      checks++;
      if (xfers !== 4 || uio_out[5] !== 1'b0 || uio_out[6] !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: transfers=%0d busy=%b valid=%b required 4/0/0",
                  xfers, uio_out[5], uio_out[6]);
      end
   endtask

   task automatic test_ignored();
      out_ready = 1'b0;
      load4(8'h21, 8'h43, 8'h65, 8'h87);
      in_valid = 1'b1;
      ui_in    = 8'hAA;
      tick();
      in_valid = 1'b0;
      wait_valid();
      in_valid = 1'b1;
      ui_in    = 8'hAA;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({uio_out[7], uo_out} !== 9'd19 || uio_out[6] !== 1'b1) begin
         errors++;
         $display("FAIL ignored_hold: data=%0d valid=%b required 19/1",
                  {uio_out[7], uo_out}, uio_out[6]);
      end
      drain_results("ignored_basic", 9'd19, 9'd22, 9'd43, 9'd50);
      load4(8'h01, 8'h10, 8'h65, 8'h87);
      drain_results("ignored_ident", 9'd5, 9'd6, 9'd7, 9'd8);
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      ui_in    = 8'hFF;
      tick();
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         errors++;
         $display("FAIL rst_load: uo_out=%h uio_out=%h required 00/00", uo_out, uio_out);
      end
      load4(8'h21, 8'h43, 8'h65, 8'h87);
      drain_results("rst_load_after", 9'd19, 9'd22, 9'd43, 9'd50);

      load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      out_ready = 1'b1;
      wait_valid();
      tick();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         errors++;
         $display("FAIL rst_send: uo_out=%h uio_out=%h required 00/00", uo_out, uio_out);
      end
      load4(8'h01, 8'h10, 8'h65, 8'h87);
      drain_results("rst_send_after", 9'd5, 9'd6, 9'd7, 9'd8);
   endtask

   task automatic test_enable();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      ui_in     = 8'h21;
      tick();
      ui_in     = 8'h43;
      tick();
      // LOAD: disabled while garbage bytes strobe
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid  = i[0];
         out_ready = ~i[0];
         ui_in     = 8'hAA;
         tick();
      end
      ena       = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      ui_in     = 8'h65;
      tick();
      ui_in     = 8'h87;
      tick();
      in_valid  = 1'b0;
      // CALC: disabled right after the last byte
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         tick();
      end
      in_valid = 1'b0;
      ena      = 1'b1;
      checks++;
      if (uio_out[5] !== 1'b1 || uio_out[6] !== 1'b0) begin
         errors++;
         $display("FAIL ena_calc: busy=%b valid=%b required 1/0", uio_out[5], uio_out[6]);
      end
      tick();
      tick();
      tick();
      checks++;
      if (uio_out[6] !== 1'b0) begin
         errors++;
         $display("FAIL ena_calc_lat3: valid=%b required 0", uio_out[6]);
      end
      tick();
      checks++;
      if (uio_out[6] !== 1'b1) begin
         errors++;
         $display("FAIL ena_calc_lat4: valid=%b required 1", uio_out[6]);
      end
      // SEND: disabled while out_ready toggles
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         out_ready = ~i[0];
         in_valid  = i[0];
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ena       = 1'b1;
      checks++;
      if ({uio_out[7], uo_out} !== 9'd19 || uio_out[6] !== 1'b1) begin
         errors++;
         $display("FAIL ena_send: data=%0d valid=%b required 19/1",
                  {uio_out[7], uo_out}, uio_out[6]);
      end
      drain_results("ena", 9'd19, 9'd22, 9'd43, 9'd50);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      ena       = 1'b1;
      ui_in     = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_ignored();
      test_reset_mid();
      test_enable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
